// File: rtl/adc_seq_pkg.sv
// Shared types and frame timing constants for the multi-channel ADC sequencer.
package adc_seq_pkg;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    localparam int         FRAME_LEN      = 16;
    localparam logic [3:0] ADDR_FIRST_CNT = 4'd2;
    localparam logic [3:0] ADDR_LAST_CNT  = 4'd4;
    localparam logic [3:0] DATA_FIRST_CNT = 4'd4;
    localparam logic [3:0] DATA_LAST_CNT  = 4'(FRAME_LEN - 1);

    // Channel-address bit sent on a given frame cycle, MSB first; zero outside the window.
    function automatic logic addr_bit(input logic [2:0] addr, input logic [3:0] cnt);
        logic [1:0] idx;
        idx = 2'(ADDR_LAST_CNT - cnt);
        if (cnt >= ADDR_FIRST_CNT && cnt <= ADDR_LAST_CNT)
            return addr[idx];
        return 1'b0;
    endfunction

endpackage

// File: rtl/adc_seq_if.sv
// Tagged result stream from the sequencer to its consumer (valid/ready).
interface adc_seq_if #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 3
);
    logic [DATA_W-1:0] smp_data;
    logic [CH_W-1:0]   smp_ch;
    logic              smp_valid;
    logic              smp_ready;

    modport master (output smp_data, output smp_ch, output smp_valid, input smp_ready);
    modport slave  (input smp_data, input smp_ch, input smp_valid, output smp_ready);
endinterface

// File: rtl/adc_rr_pick.sv
// Round-robin channel picker: lowest set mask bit at or above start, wrapping.
module adc_rr_pick #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   start,
    output logic [CH_W-1:0]   pick,
    output logic              none
);

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        pick = '0;
        none = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[(int'(start) + k) % NUM_CH]) begin
                pick = CH_W'((int'(start) + k) % NUM_CH);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multi-channel conversion sequencer for the 16-clock serial ADC frame.
// Results are pipelined one frame: each one is tagged with the address sent in the previous frame.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int DATA_W  = 12,
    parameter int GAP_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              adc_cs_n,
    output logic              adc_addr,
    input  logic              adc_sdo,
    adc_seq_if.master         smp,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t            state;
    logic [3:0]        cnt;
    logic [GW-1:0]     gap_cnt;
    logic [CH_W-1:0]   addr_cur;
    logic [CH_W-1:0]   addr_prev;
    logic [CH_W-1:0]   rr_ptr;
    logic              prime;
    logic              pend;
    logic [CH_W-1:0]   pend_ch;
    logic [DATA_W-1:0] shreg;
    logic [CH_W-1:0]   pick;
    logic              none;

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
        return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
    endfunction

    // rr_ptr always sits one past the last launched channel, so the same picker
    // serves both the first pick from IDLE and the strictly-after pick in GAP.
    adc_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
        .mask  (ch_mask),
        .start (rr_ptr),
        .pick  (pick),
        .none  (none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            gap_cnt       <= '0;
            addr_cur      <= '0;
            addr_prev     <= '0;
            rr_ptr        <= '0;
            prime         <= 1'b1;
            pend          <= 1'b0;
            pend_ch       <= '0;
            shreg         <= '0;
            adc_cs_n      <= 1'b1;
            adc_addr      <= 1'b0;
            smp.smp_data  <= '0;
            smp.smp_ch    <= '0;
            smp.smp_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            // Result delivery runs independently of the sequencing state.
            pend <= 1'b0;
            if (clr_overrun)
                overrun <= 1'b0;
            if (pend) begin
                if (!smp.smp_valid || smp.smp_ready) begin
                    smp.smp_data  <= shreg;
                    smp.smp_ch    <= pend_ch;
                    smp.smp_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (smp.smp_valid && smp.smp_ready) begin
                smp.smp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    adc_cs_n <= 1'b1;
                    adc_addr <= 1'b0;
                    if (en && !none) begin
                        state    <= FRAME;
                        cnt      <= '0;
                        addr_cur <= pick;
                        rr_ptr   <= wrap_inc(pick);
                        prime    <= 1'b1;
                        adc_cs_n <= 1'b0;
                    end
                end
                FRAME: begin
                    if (cnt >= DATA_FIRST_CNT)
                        shreg <= {shreg[DATA_W-2:0], adc_sdo};
                    if (cnt == DATA_LAST_CNT) begin
                        pend      <= !prime;
                        pend_ch   <= addr_prev;
                        addr_prev <= addr_cur;
                        prime     <= 1'b0;
                        adc_cs_n  <= 1'b1;
                        adc_addr  <= 1'b0;
                        gap_cnt   <= GW'(GAP_CYC - 1);
                        state     <= en ? GAP : IDLE;
                    end else begin
                        cnt      <= cnt + 4'd1;
                        adc_addr <= addr_bit(3'(addr_cur), cnt + 4'd1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (en && !none) begin
                            state    <= FRAME;
                            cnt      <= '0;
                            addr_cur <= pick;
                            rr_ptr   <= wrap_inc(pick);
                            adc_cs_n <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
